// File: rtl/gcn_pkg.sv
// -----------------------------------------------------------------------------
// gcn_pkg
// Shared definitions for the GCN operand server: default geometry, the
// load/serve state encoding, element and COO word types, and a width helper.
// -----------------------------------------------------------------------------
package gcn_pkg;

  localparam int GCN_WEIGHT_ROWS     = 96;
  localparam int GCN_WEIGHT_COLS     = 3;
  localparam int GCN_FEATURE_ROWS    = 6;
  localparam int GCN_WEIGHT_WIDTH    = 5;
  localparam int GCN_ADDRESS_WIDTH   = 13;
  localparam int GCN_FEATURE_BASE    = 512;
  localparam int GCN_COO_NUM_OF_COLS = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_F = 3'd2,
    LOAD_C = 3'd3,
    SERVE  = 3'd4
  } gcn_state_t;

  typedef logic [GCN_WEIGHT_WIDTH-1:0]          element_t;
  typedef logic [0:GCN_WEIGHT_COLS-1][1:0]      coo_word_t;

  // Bits needed to index 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    if (v <= 2) begin
      return 1;
    end else begin
      return $clog2(v);
    end
  endfunction

endpackage

// File: rtl/gcn_load_counter.sv
// -----------------------------------------------------------------------------
// gcn_load_counter
// Lane/row position counter for the host load stream. Lane runs 0..lane_max,
// then wraps and the row advances; row wraps after row_max. The limits are
// inputs so one instance can be retargeted per load phase.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_clear        synchronous clear of both counters (wins over advance)
//   i_advance      step one element
//   i_lane_max     last lane index of the current phase
//   i_row_max      last row index of the current phase
//   o_lane, o_row  current position
//   o_last         position is the final element of the phase
// -----------------------------------------------------------------------------
module gcn_load_counter #(
  parameter int LANE_W = 7,
  parameter int ROW_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic [LANE_W-1:0] i_lane_max,
  input  logic [ROW_W-1:0]  i_row_max,
  output logic [LANE_W-1:0] o_lane,
  output logic [ROW_W-1:0]  o_row,
  output logic              o_last
);

  logic [LANE_W-1:0] r_lane;
  logic [ROW_W-1:0]  r_row;

  // Lane/row stepping with wrap on the configured limits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lane <= '0;
      r_row  <= '0;
    end else if (i_clear) begin
      r_lane <= '0;
      r_row  <= '0;
    end else if (i_advance) begin
      if (r_lane == i_lane_max) begin
        r_lane <= '0;
        if (r_row == i_row_max) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + ROW_W'(1);
        end
      end else begin
        r_lane <= r_lane + LANE_W'(1);
      end
    end else begin
      r_lane <= r_lane;
      r_row  <= r_row;
    end
  end

  assign o_lane = r_lane;
  assign o_row  = r_row;
  assign o_last = (r_lane == i_lane_max) && (r_row == i_row_max);

endmodule

// File: rtl/gcn_operand_server.sv
// -----------------------------------------------------------------------------
// gcn_operand_server
// Responder for GCN operand fetch. After reset the host streams weights,
// then features, then COO entries, one element per accepted cycle. Once the
// image is complete gcn_start pulses for one cycle and the block serves
// vector reads (registered, 1-cycle latency) and COO reads (combinational).
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   load_valid     host element valid
//   load_data      host element (COO phase uses bits [1:0])
//   load_ready     element accepted this cycle when load_valid is high
//   gcn_start      one-cycle pulse on the first serving cycle
//   mem_ready      image loaded, serving reads
//   enable_read    vector read request
//   read_address   vector address (weights at 0.., features at FEATURE_BASE..)
//   data_in        read vector, unpacked [0:WEIGHT_ROWS-1]
//   coo_address    COO word address
//   coo_in         COO word, entries [0:WEIGHT_COLS-1]
//   read_err       sticky illegal-read flag
// -----------------------------------------------------------------------------
module gcn_operand_server
  import gcn_pkg::*;
#(
  parameter int WEIGHT_ROWS     = GCN_WEIGHT_ROWS,
  parameter int WEIGHT_COLS     = GCN_WEIGHT_COLS,
  parameter int FEATURE_ROWS    = GCN_FEATURE_ROWS,
  parameter int WEIGHT_WIDTH    = GCN_WEIGHT_WIDTH,
  parameter int ADDRESS_WIDTH   = GCN_ADDRESS_WIDTH,
  parameter int FEATURE_BASE    = GCN_FEATURE_BASE,
  parameter int COO_NUM_OF_COLS = GCN_COO_NUM_OF_COLS,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [WEIGHT_WIDTH-1:0]  load_data,
  output logic                     load_ready,
  output logic                     gcn_start,
  output logic                     mem_ready,
  input  logic                     enable_read,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [WEIGHT_WIDTH-1:0]  data_in [0:WEIGHT_ROWS-1],
  input  logic [COO_BW-1:0]        coo_address,
  output logic [0:WEIGHT_COLS-1][1:0] coo_in,
  output logic                     read_err
);

  localparam int LANE_W   = clog2_min1((WEIGHT_ROWS > WEIGHT_COLS) ? WEIGHT_ROWS : WEIGHT_COLS);
  localparam int ROW_MAXV = (FEATURE_ROWS > COO_NUM_OF_COLS) ?
                            ((FEATURE_ROWS > WEIGHT_COLS) ? FEATURE_ROWS : WEIGHT_COLS) :
                            ((COO_NUM_OF_COLS > WEIGHT_COLS) ? COO_NUM_OF_COLS : WEIGHT_COLS);
  localparam int ROW_W    = clog2_min1(ROW_MAXV);
  localparam int WIDX_W   = clog2_min1(WEIGHT_COLS);
  localparam int FIDX_W   = clog2_min1(FEATURE_ROWS);

  // Control state
  gcn_state_t r_state;
  gcn_state_t w_next;
  logic       r_load_ready;
  logic       r_gcn_start;
  logic       r_mem_ready;
  logic       r_read_err;

  // Load path
  logic              w_accept;
  logic              w_last;
  logic [LANE_W-1:0] w_lane;
  logic [ROW_W-1:0]  w_row;
  logic [LANE_W-1:0] w_lane_max;
  logic [ROW_W-1:0]  w_row_max;

  // Storage (not reset: always fully rewritten by the load stream)
  logic [WEIGHT_WIDTH-1:0]     r_weight  [0:WEIGHT_COLS-1][0:WEIGHT_ROWS-1];
  logic [WEIGHT_WIDTH-1:0]     r_feature [0:FEATURE_ROWS-1][0:WEIGHT_ROWS-1];
  logic [0:WEIGHT_COLS-1][1:0] r_coo     [0:COO_NUM_OF_COLS-1];

  // Read path
  logic [WEIGHT_WIDTH-1:0]  r_data   [0:WEIGHT_ROWS-1];
  logic [WEIGHT_WIDTH-1:0]  w_rd_vec [0:WEIGHT_ROWS-1];
  logic                     w_rd_err;
  logic                     w_is_weight;
  logic                     w_is_feature;
  logic [ADDRESS_WIDTH-1:0] w_f_off;
  logic [WIDX_W-1:0]        w_widx;
  logic [FIDX_W-1:0]        w_fidx;
  logic                     w_coo_ok;
  logic                     w_coo_err;

  assign w_accept = load_valid && r_load_ready;

  // Per-phase counter limits.
  always_comb begin
    w_lane_max = LANE_W'(WEIGHT_ROWS - 1);
    w_row_max  = '0;
    case (r_state)
      LOAD_W: begin
        w_lane_max = LANE_W'(WEIGHT_ROWS - 1);
        w_row_max  = ROW_W'(WEIGHT_COLS - 1);
      end
      LOAD_F: begin
        w_lane_max = LANE_W'(WEIGHT_ROWS - 1);
        w_row_max  = ROW_W'(FEATURE_ROWS - 1);
      end
      LOAD_C: begin
        w_lane_max = LANE_W'(WEIGHT_COLS - 1);
        w_row_max  = ROW_W'(COO_NUM_OF_COLS - 1);
      end
      default: begin
        w_lane_max = LANE_W'(WEIGHT_ROWS - 1);
        w_row_max  = '0;
      end
    endcase
  end

  gcn_load_counter #(
    .LANE_W (LANE_W),
    .ROW_W  (ROW_W)
  ) u_load_counter (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_clear    (w_accept && w_last),
    .i_advance  (w_accept),
    .i_lane_max (w_lane_max),
    .i_row_max  (w_row_max),
    .o_lane     (w_lane),
    .o_row      (w_row),
    .o_last     (w_last)
  );

  // Next-state: each load phase ends on acceptance of its final element.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        w_next = LOAD_W;
      end
      LOAD_W: begin
        if (w_accept && w_last) begin
          w_next = LOAD_F;
        end else begin
          w_next = LOAD_W;
        end
      end
      LOAD_F: begin
        if (w_accept && w_last) begin
          w_next = LOAD_C;
        end else begin
          w_next = LOAD_F;
        end
      end
      LOAD_C: begin
        if (w_accept && w_last) begin
          w_next = SERVE;
        end else begin
          w_next = LOAD_C;
        end
      end
      SERVE: begin
        w_next = SERVE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State and status outputs, registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_load_ready <= 1'b0;
      r_gcn_start  <= 1'b0;
      r_mem_ready  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_load_ready <= (w_next == LOAD_W) || (w_next == LOAD_F) || (w_next == LOAD_C);
      r_gcn_start  <= (w_next == SERVE) && (r_state != SERVE);
      r_mem_ready  <= (w_next == SERVE);
    end
  end

  // Storage writes from the host stream.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      case (r_state)
        LOAD_W:  r_weight[w_row[WIDX_W-1:0]][w_lane] <= load_data;
        LOAD_F:  r_feature[w_row[FIDX_W-1:0]][w_lane] <= load_data;
        LOAD_C:  r_coo[w_row[COO_BW-1:0]][w_lane[WIDX_W-1:0]] <= load_data[1:0];
        default: ;
      endcase
    end
  end

  // Address decode. Unsigned wrap of the offset makes addresses below the
  // feature base fall out of range too.
  assign w_f_off      = read_address - ADDRESS_WIDTH'(FEATURE_BASE);
  assign w_is_weight  = (read_address < ADDRESS_WIDTH'(WEIGHT_COLS));
  assign w_is_feature = (w_f_off < ADDRESS_WIDTH'(FEATURE_ROWS));
  assign w_widx       = read_address[WIDX_W-1:0];
  assign w_fidx       = w_f_off[FIDX_W-1:0];
  assign w_coo_ok     = ({1'b0, coo_address} < (COO_BW + 1)'(COO_NUM_OF_COLS));
  assign w_coo_err    = (r_state == SERVE) && !w_coo_ok;

  // Vector read mux; anything outside SERVE or outside both windows is an error.
  always_comb begin
    for (int l = 0; l < WEIGHT_ROWS; l++) begin
      w_rd_vec[l] = '0;
    end
    w_rd_err = 1'b0;
    if (r_state == SERVE) begin
      if (w_is_weight) begin
        for (int l = 0; l < WEIGHT_ROWS; l++) begin
          w_rd_vec[l] = r_weight[w_widx][l];
        end
      end else if (w_is_feature) begin
        for (int l = 0; l < WEIGHT_ROWS; l++) begin
          w_rd_vec[l] = r_feature[w_fidx][l];
        end
      end else begin
        w_rd_err = 1'b1;
      end
    end else begin
      w_rd_err = 1'b1;
    end
  end

  // Registered read data (holds when idle) and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < WEIGHT_ROWS; l++) begin
        r_data[l] <= '0;
      end
      r_read_err <= 1'b0;
    end else begin
      if (enable_read) begin
        for (int l = 0; l < WEIGHT_ROWS; l++) begin
          r_data[l] <= w_rd_vec[l];
        end
      end
      if ((enable_read && w_rd_err) || w_coo_err) begin
        r_read_err <= 1'b1;
      end else begin
        r_read_err <= r_read_err;
      end
    end
  end

  // COO word is combinational so the requester sees it in the address cycle.
  always_comb begin
    coo_in = '0;
    if ((r_state == SERVE) && w_coo_ok) begin
      coo_in = r_coo[coo_address];
    end else begin
      coo_in = '0;
    end
  end

  assign data_in    = r_data;
  assign load_ready = r_load_ready;
  assign gcn_start  = r_gcn_start;
  assign mem_ready  = r_mem_ready;
  assign read_err   = r_read_err;

endmodule

// File: tb/tb_gcn_operand_server.sv
// -----------------------------------------------------------------------------
// tb_gcn_operand_server
// Scenario tasks for the GCN operand server. Vector reads push the expected
// vector to a scoreboard queue when the address is driven and pop it when the
// registered data appears one cycle later.
// -----------------------------------------------------------------------------
module tb_gcn_operand_server;

  localparam int WR   = 96;
  localparam int WC   = 3;
  localparam int FR   = 6;
  localparam int WW   = 5;
  localparam int AW   = 13;
  localparam int FB   = 512;
  localparam int CN   = 6;
  localparam int CBW  = 3;
  localparam int NTOT = WR*WC + WR*FR + WC*CN;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_valid;
  logic [WW-1:0]     load_data;
  logic              load_ready;
  logic              gcn_start;
  logic              mem_ready;
  logic              enable_read;
  logic [AW-1:0]     read_address;
  logic [WW-1:0]     data_in [0:WR-1];
  logic [CBW-1:0]    coo_address;
  logic [0:WC-1][1:0] coo_in;
  logic              read_err;

  int checks   = 0;
  int failures = 0;
  logic [WR*WW-1:0] exp_q [$];
  logic             model_err;

  always #5 clk = ~clk;

  gcn_operand_server dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .gcn_start    (gcn_start),
    .mem_ready    (mem_ready),
    .enable_read  (enable_read),
    .read_address (read_address),
    .data_in      (data_in),
    .coo_address  (coo_address),
    .coo_in       (coo_in),
    .read_err     (read_err)
  );

  function automatic logic [WW-1:0] w_val(input int r, input int l);
    return WW'((r + l) % 32);
  endfunction

  function automatic logic [WW-1:0] f_val(input int r, input int l);
    return WW'((3*r + l) % 32);
  endfunction

  function automatic logic [1:0] c_val(input int r, input int e);
    return 2'((r + e) % 4);
  endfunction

  // k-th element of the host stream.
  function automatic logic [WW-1:0] stream_val(input int k);
    int j;
    if (k < WR*WC) begin
      return w_val(k / WR, k % WR);
    end else if (k < WR*WC + WR*FR) begin
      j = k - WR*WC;
      return f_val(j / WR, j % WR);
    end else begin
      j = k - WR*WC - WR*FR;
      return {3'b000, c_val(j / WC, j % WC)};
    end
  endfunction

  function automatic logic [WR*WW-1:0] exp_vec(input int a);
    logic [WR*WW-1:0] v;
    v = '0;
    for (int l = 0; l < WR; l++) begin
      if (a < WC) v[(WR-1-l)*WW +: WW] = w_val(a, l);
      else if (a >= FB && a < FB + FR) v[(WR-1-l)*WW +: WW] = f_val(a - FB, l);
    end
    return v;
  endfunction

  function automatic logic exp_err(input int a);
    return !((a < WC) || (a >= FB && a < FB + FR));
  endfunction

  function automatic logic [WR*WW-1:0] flat_data();
    logic [WR*WW-1:0] v;
    for (int l = 0; l < WR; l++) v[(WR-1-l)*WW +: WW] = data_in[l];
    return v;
  endfunction

  function automatic logic [0:WC-1][1:0] exp_coo(input int r);
    logic [0:WC-1][1:0] w;
    for (int e = 0; e < WC; e++) w[e] = c_val(r, e);
    return w;
  endfunction

  // Stream elements until target accepted or the cycle budget runs out.
  task automatic run_load(input int target, input bit rnd, output int starts,
                          output int k_at_start, output bit mr_at_start, output bit timed_out);
    int k;
    int cyc;
    bit v;
    bit acc;
    k = 0; cyc = 0; starts = 0; k_at_start = -1; mr_at_start = 1'b0;
    while (k < target && cyc < 5000) begin
      v = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      load_valid = v;
      load_data  = stream_val(k);
      acc = v && load_ready;
      @(posedge clk); #1;
      if (acc) k++;
      if (gcn_start) begin
        starts++;
        k_at_start  = k;
        mr_at_start = mem_ready;
      end
      cyc++;
    end
    load_valid = 1'b0;
    timed_out  = (k < target);
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b0; load_data = '0; enable_read = 1'b0;
    read_address = '0; coo_address = '0; model_err = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready got=%b exp=0", load_ready); end
    checks++; if (gcn_start !== 1'b0) begin failures++; $display("FAIL reset_gcn_start got=%b exp=0", gcn_start); end
    checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL reset_mem_ready got=%b exp=0", mem_ready); end
    checks++; if (read_err !== 1'b0) begin failures++; $display("FAIL reset_read_err got=%b exp=0", read_err); end
    checks++; if (flat_data() !== '0) begin failures++; $display("FAIL reset_data_in got=%h exp=0", flat_data()); end
    checks++; if (coo_in !== '0) begin failures++; $display("FAIL reset_coo_in got=%h exp=0", coo_in); end
    reset = 1'b0;
  endtask

  task automatic test_load(input bit rnd);
    int starts; int k_at; bit mr_at; bit to; int extra;
    run_load(NTOT, rnd, starts, k_at, mr_at, to);
    checks++; if (to) begin failures++; $display("FAIL load_timeout got=unfinished exp=%0d_elements", NTOT); end
    // Extra valid cycles in SERVE must be ignored.
    extra = 0;
    load_valid = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (gcn_start) extra++;
    end
    load_valid = 1'b0;
    checks++; if (starts + extra !== 1) begin failures++; $display("FAIL load_start_count got=%0d exp=1", starts + extra); end
    checks++; if (k_at !== NTOT) begin failures++; $display("FAIL load_start_position got=%0d exp=%0d", k_at, NTOT); end
    checks++; if (mr_at !== 1'b1) begin failures++; $display("FAIL load_mem_ready_with_start got=%b exp=1", mr_at); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL serve_load_ready got=%b exp=0", load_ready); end
    checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL serve_mem_ready got=%b exp=1", mem_ready); end
    checks++; if (read_err !== model_err) begin failures++; $display("FAIL load_read_err got=%b exp=%b", read_err, model_err); end
  endtask

  task automatic test_weight_read();
    logic [WR*WW-1:0] e;
    enable_read = 1'b1; read_address = AW'(2);
    exp_q.push_back(exp_vec(2)); model_err = model_err | exp_err(2);
    @(posedge clk); #1;
    enable_read = 1'b0;
    e = exp_q.pop_front();
    checks++; if (flat_data() !== e) begin failures++; $display("FAIL weight_vec got=%h exp=%h", flat_data(), e); end
    checks++; if (data_in[0] !== 5'd2) begin failures++; $display("FAIL weight_lane0 got=%0d exp=2", data_in[0]); end
    checks++; if (data_in[95] !== 5'd1) begin failures++; $display("FAIL weight_lane95 got=%0d exp=1", data_in[95]); end
    checks++; if (read_err !== 1'b0) begin failures++; $display("FAIL weight_read_err got=%b exp=0", read_err); end
  endtask

  task automatic test_feature_read();
    int addrs [2];
    logic [WW-1:0] l10 [2];
    logic [WR*WW-1:0] e;
    addrs[0] = 517; addrs[1] = 512;
    l10[0] = 5'd25; l10[1] = 5'd10;
    for (int i = 0; i < 2; i++) begin
      enable_read = 1'b1; read_address = AW'(addrs[i]);
      exp_q.push_back(exp_vec(addrs[i])); model_err = model_err | exp_err(addrs[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++; if (flat_data() !== e) begin failures++; $display("FAIL feature_vec_%0d got=%h exp=%h", addrs[i], flat_data(), e); end
      checks++; if (data_in[10] !== l10[i]) begin failures++; $display("FAIL feature_lane10_%0d got=%0d exp=%0d", addrs[i], data_in[10], l10[i]); end
    end
    enable_read = 1'b0;
    // With enable_read low the last vector must hold.
    read_address = AW'(1);
    repeat (2) @(posedge clk); #1;
    checks++; if (flat_data() !== exp_vec(512)) begin failures++; $display("FAIL hold_data got=%h exp=%h", flat_data(), exp_vec(512)); end
    checks++; if (read_err !== 1'b0) begin failures++; $display("FAIL feature_read_err got=%b exp=0", read_err); end
  endtask

  task automatic test_coo_read();
    for (int r = 0; r < CN; r++) begin
      coo_address = CBW'(r);
      #1;
      checks++; if (coo_in !== exp_coo(r)) begin failures++; $display("FAIL coo_word_%0d got=%h exp=%h", r, coo_in, exp_coo(r)); end
    end
    @(posedge clk); #1;
    checks++; if (read_err !== model_err) begin failures++; $display("FAIL coo_legal_err got=%b exp=%b", read_err, model_err); end
  endtask

  task automatic test_coo_illegal();
    coo_address = CBW'(6);
    #1;
    checks++; if (coo_in !== '0) begin failures++; $display("FAIL coo_illegal_word got=%h exp=0", coo_in); end
    checks++; if (read_err !== 1'b0) begin failures++; $display("FAIL coo_err_before_edge got=%b exp=0", read_err); end
    @(posedge clk); #1;
    coo_address = CBW'(0);
    model_err = 1'b1;
    checks++; if (read_err !== 1'b1) begin failures++; $display("FAIL coo_err_after_edge got=%b exp=1", read_err); end
  endtask

  task automatic test_illegal_read();
    logic [WR*WW-1:0] e;
    enable_read = 1'b1; read_address = AW'(3);
    exp_q.push_back(exp_vec(3)); model_err = model_err | exp_err(3);
    @(posedge clk); #1;
    enable_read = 1'b0;
    e = exp_q.pop_front();
    checks++; if (flat_data() !== e) begin failures++; $display("FAIL illegal_vec got=%h exp=%h", flat_data(), e); end
    checks++; if (read_err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", read_err); end
  endtask

  task automatic test_back_to_back();
    int addrs [9];
    logic [WR*WW-1:0] e;
    for (int i = 0; i < 3; i++) addrs[i] = i;
    for (int i = 0; i < 6; i++) addrs[3+i] = FB + i;
    for (int i = 0; i < 9; i++) begin
      enable_read = 1'b1; read_address = AW'(addrs[i]);
      exp_q.push_back(exp_vec(addrs[i])); model_err = model_err | exp_err(addrs[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++; if (flat_data() !== e) begin failures++; $display("FAIL b2b_vec_%0d got=%h exp=%h", addrs[i], flat_data(), e); end
      checks++; if (read_err !== model_err) begin failures++; $display("FAIL b2b_err_%0d got=%b exp=%b", addrs[i], read_err, model_err); end
    end
    enable_read = 1'b0;
  endtask

  task automatic test_reset_midload();
    int starts; int k_at; bit mr_at; bit to;
    // Async reset out of SERVE with live outputs.
    coo_address = CBW'(5);
    #2 reset = 1'b1;
    #1;
    checks++; if (flat_data() !== '0) begin failures++; $display("FAIL async_data_in got=%h exp=0", flat_data()); end
    checks++; if (read_err !== 1'b0) begin failures++; $display("FAIL async_read_err got=%b exp=0", read_err); end
    checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL async_mem_ready got=%b exp=0", mem_ready); end
    checks++; if (coo_in !== '0) begin failures++; $display("FAIL async_coo_in got=%h exp=0", coo_in); end
    @(posedge clk); #1;
    reset = 1'b0; model_err = 1'b0; coo_address = '0;
    run_load(100, 1'b0, starts, k_at, mr_at, to);
    checks++; if (to || starts != 0) begin failures++; $display("FAIL partial_load got=starts%0d_to%0d exp=starts0_to0", starts, to); end
    // Read outside SERVE is an error and returns zero.
    enable_read = 1'b1; read_address = AW'(2);
    @(posedge clk); #1;
    enable_read = 1'b0;
    checks++; if (read_err !== 1'b1) begin failures++; $display("FAIL load_phase_read_err got=%b exp=1", read_err); end
    checks++; if (flat_data() !== '0) begin failures++; $display("FAIL load_phase_data got=%h exp=0", flat_data()); end
    #2 reset = 1'b1;
    #1;
    checks++; if (read_err !== 1'b0) begin failures++; $display("FAIL midload_read_err got=%b exp=0", read_err); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL midload_load_ready got=%b exp=0", load_ready); end
    @(posedge clk); #1;
    reset = 1'b0; model_err = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load(1'b0);
    test_weight_read();
    test_feature_read();
    test_coo_read();
    test_illegal_read();
    test_back_to_back();
    test_reset_midload();
    test_load(1'b1);
    test_back_to_back();
    test_coo_read();
    test_coo_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gcn_operand_server.md
Name: gcn_operand_server

Overview:
- Responder side of the GCN operand-fetch interface. Serves weight and feature vectors on data_in in response to read_address/enable_read. Serves COO adjacency entries on coo_in in response to coo_address.
- Contents are streamed in from a host one element at a time before inference. A single-cycle gcn_start pulse is issued once the whole image is loaded.

Parameters:
- WEIGHT_ROWS, 96, elements per weight vector (= FEATURE_COLS)
- WEIGHT_COLS, 3, number of weight vectors; also entries per COO word
- FEATURE_ROWS, 6, number of feature vectors
- WEIGHT_WIDTH, 5, element width (features and weights)
- ADDRESS_WIDTH, 13, read_address width
- FEATURE_BASE, 512, read_address of feature row 0
- COO_NUM_OF_COLS, 6, COO memory depth
- COO_BW, $clog2(COO_NUM_OF_COLS), coo_address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- load_valid  in  1  host element valid
- load_data  in  WEIGHT_WIDTH  host element; COO phase uses bits [1:0] only
- load_ready  out  1  block accepts an element this cycle
- gcn_start  out  1  one-cycle pulse when load completes
- mem_ready  out  1  image loaded, serving reads
- enable_read  in  1  read request
- read_address  in  ADDRESS_WIDTH  vector address
- data_in  out  WEIGHT_WIDTH x WEIGHT_ROWS  unpacked [0:WEIGHT_ROWS-1] vector
- coo_address  in  COO_BW  COO word address
- coo_in  out  packed [0:WEIGHT_COLS-1][1:0]  COO word
- read_err  out  1  sticky: illegal read seen

Behaviour:
- Reset (async, active-high):
  - state=IDLE; counters=0.
  - data_in all 0, coo_in 0, load_ready 0, gcn_start 0, mem_ready 0, read_err 0.
  - Storage arrays are not reset.
- FSM states: IDLE, LOAD_W, LOAD_F, LOAD_C, SERVE.
  - IDLE: goes to LOAD_W on the next cycle after reset deasserts.
  - LOAD_*: load_ready=1. An element is accepted when load_valid && load_ready.
- Load order and counters:
  - lane counter counts 0..L-1 and row counter counts 0..R-1. Lane wraps to 0 and row increments on the last lane.
  - LOAD_W: L=WEIGHT_ROWS, R=WEIGHT_COLS. Element stored at weight[row][lane].
  - LOAD_F: L=WEIGHT_ROWS, R=FEATURE_ROWS. Element stored at feature[row][lane].
  - LOAD_C: L=WEIGHT_COLS, R=COO_NUM_OF_COLS. load_data[1:0] stored at coo[row][lane].
  - On acceptance of the last element of a phase (lane=L-1, row=R-1): counters clear and the FSM advances LOAD_W->LOAD_F->LOAD_C->SERVE.
  - Totals at defaults: 288 + 576 + 18 = 882 accepted elements.
- Entry to SERVE:
  - gcn_start=1 for exactly the first SERVE cycle.
  - mem_ready=1 and load_ready=0 from the first SERVE cycle until reset.
  - load_valid in SERVE is ignored, with no error.
- Vector reads (SERVE, enable_read=1): data_in registered, 1-cycle latency.
  - addr < WEIGHT_COLS: data_in <= weight[addr].
  - FEATURE_BASE <= addr < FEATURE_BASE+FEATURE_ROWS: data_in <= feature[addr-FEATURE_BASE].
  - Any other addr: data_in <= all 0, read_err <= 1.
  - enable_read=0: data_in holds its last value.
- enable_read=1 outside SERVE: data_in <= 0, read_err <= 1, no state change.
- COO reads: coo_in is combinational from coo_address in SERVE, and 0 outside SERVE.
  - coo_address >= COO_NUM_OF_COLS returns 0 and sets read_err. The error flag is registered on the next edge, evaluated only in SERVE.
- read_err is cleared only by reset.
- Reset mid-load: everything restarts from LOAD_W; partially written data is overwritten by the new stream.
- Back-to-back reads: a new address every cycle is sustained, with data following 1 cycle behind each address.

Decomposition:
- Shared package gcn_pkg:
  - state enum (IDLE, LOAD_W, LOAD_F, LOAD_C, SERVE);
  - FEATURE_BASE constant;
  - element typedef logic [WEIGHT_WIDTH-1:0];
  - coo word typedef.
- One sub-module: gcn_load_counter, a lane/row counter with configurable L and R, a last-element flag and synchronous clear. It is instantiated once and reconfigured per phase by muxing L and R on state.

Test Plan:
- Load ramp, then serve:
  - Stimulus: stream weight[r][l]=(r+l)%32, feature[r][l]=(3r+l)%32, coo[r][e]=(r+e)%4. Hold load_valid constantly high.
  - Response: gcn_start pulses exactly once, 882 accepted elements after load starts. mem_ready rises in the same cycle as gcn_start.
- Weight read:
  - Stimulus: read_address=2, enable_read=1.
  - Response: the next cycle, data_in[0]=2, data_in[95]=(2+95)%32=1. read_err stays 0.
- Feature read:
  - Stimulus: read_address=517, then 512 on the following cycle.
  - Response: data_in[10]=25, then data_in[10]=10, each one cycle after its address.
- Illegal vector address:
  - Stimulus: read_address=3.
  - Response: data_in all 0 the next cycle, and read_err=1 stays set through later legal reads.
- COO read:
  - coo_address=5: coo_in = {1,2,3} (entries 0..2) in the same cycle.
  - coo_address=6: coo_in=0 and read_err=1 after the edge.
- Reset and back-pressure:
  - Toggling load_valid randomly (50%): same final image as the ramp test.
  - Asserting reset after 100 elements: all outputs return to 0 immediately, asynchronously. A full reload then produces a single gcn_start and correct readback.
